// File: rtl/matrix_scan_multi_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : matrix_scan_multi_if                                    |
// | Purpose  : Frame-store read port of the multi-panel scan engine.   |
// |            The scan engine is the master; it issues a read strobe  |
// |            with row/bit, and the store answers one bit per channel |
// |            on the following cycle.                                 |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
interface matrix_scan_multi_if #(
  parameter int CHANNELS  = 3,
  parameter int ROW_BITS  = 4,
  parameter int SHIFT_LEN = 48
);
  localparam int BIT_W = $clog2(SHIFT_LEN);

  logic                rd_en;
  logic [ROW_BITS-1:0] rd_row;
  logic [BIT_W-1:0]    rd_bit;
  logic [CHANNELS-1:0] rd_data;

  modport master (output rd_en, output rd_row, output rd_bit, input rd_data);
  modport slave  (input rd_en, input rd_row, input rd_bit, output rd_data);
endinterface
`default_nettype wire

// File: rtl/matrix_scan_multi.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : matrix_scan_multi                                       |
// | Purpose  : Shared scan timing engine for CHANNELS LED panels run   |
// |            in lockstep: common DCLK/LE/GCLK/row address, one SDO   |
// |            per panel, pixel bits fetched from an external frame    |
// |            store with one cycle of read latency.                   |
// | Options  : MATRIX_ROW_BD_SWAP_EN - swap row_addr bits 1 and 3 on   |
// |            output for panels wired with B/D crossed (ROW_BITS>=4). |
// | Timing   : cycles per row = SHIFT_LEN*2*CLK_DIV + 2*CLK_DIV        |
// |            + BLANK_CYCLES + GCLK_PULSES*2*CLK_DIV; state changes   |
// |            add no extra cycles while en stays high.                |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module matrix_scan_multi #(
  parameter int CHANNELS     = 3,
  parameter int ROWS         = 16,
  parameter int ROW_BITS     = 4,
  parameter int SHIFT_LEN    = 48,
  parameter int CLK_DIV      = 2,
  parameter int BLANK_CYCLES = 8,
  parameter int GCLK_PULSES  = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [7:0]           brightness,
  matrix_scan_multi_if.master  fs,
  output logic [CHANNELS-1:0]  sdo,
  output logic                 dclk,
  output logic                 le,
  output logic                 gclk,
  output logic [ROW_BITS-1:0]  row_addr,
  output logic                 frame_start,
  output logic                 busy
);
  localparam int PERIOD = 2 * CLK_DIV;
  localparam int PH_W   = $clog2(PERIOD);
  localparam int BIT_W  = $clog2(SHIFT_LEN);
  localparam int PW     = $clog2(GCLK_PULSES + 1);
  localparam int BW     = $clog2(BLANK_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SHIFT   = 3'd1,
    S_LATCH   = 3'd2,
    S_BLANK   = 3'd3,
    S_DISPLAY = 3'd4
  } state_t;

  state_t              state, state_nx;
  logic [PH_W-1:0]     ph;          // phase within one DCLK/GCLK period
  logic [BIT_W-1:0]    bit_idx;     // bit being shifted in the current row
  logic [PW-1:0]       pulse;       // GCLK period index within the display slot
  logic [PW-1:0]       bright_lim;  // brightness clamped to GCLK_PULSES, held per row
  logic [BW-1:0]       blank_cnt;
  logic [ROW_BITS-1:0] row;         // row being shifted / displayed
  logic [ROW_BITS-1:0] row_q;       // row currently driven to the panels
  logic [CHANNELS-1:0] sdo_q;

  logic                ph_last, bit_last, pulse_last, blank_last, row_wrap;
  logic [PW-1:0]       bright_sat;

  assign ph_last    = (ph == PH_W'(PERIOD - 1));
  assign bit_last   = (bit_idx == BIT_W'(SHIFT_LEN - 1));
  assign pulse_last = (pulse == PW'(GCLK_PULSES - 1));
  assign blank_last = (blank_cnt == BW'(BLANK_CYCLES - 1));
  assign row_wrap   = (row == ROW_BITS'(ROWS - 1));
  assign bright_sat = (int'(brightness) > GCLK_PULSES) ? PW'(GCLK_PULSES) : PW'(brightness);

  // State register; reset aborts any row in progress.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Phase/bit/pulse counters, row sequencing, latched brightness and data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      ph          <= '0;
      bit_idx     <= '0;
      pulse       <= '0;
      blank_cnt   <= '0;
      row         <= '0;
      row_q       <= '0;
      bright_lim  <= '0;
      sdo_q       <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      case (state)
        S_IDLE: begin
          ph      <= '0;
          bit_idx <= '0;
          sdo_q   <= '0;
        end
        S_SHIFT: begin
          // Store data arrives one cycle after the ph=0 request.
          if (ph == PH_W'(1)) sdo_q <= fs.rd_data;
          if (ph_last) begin
            ph <= '0;
            if (bit_last) begin
              bit_idx    <= '0;
              sdo_q      <= '0;
              bright_lim <= bright_sat;   // captured on the edge entering LATCH
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            ph <= ph + 1'b1;
          end
        end
        S_LATCH: begin
          ph        <= ph_last ? '0 : ph + 1'b1;
          blank_cnt <= '0;
        end
        S_BLANK: begin
          // Row select moves only here, with GCLK held low, to avoid ghosting.
          if (blank_cnt == '0) row_q <= row;
          blank_cnt <= blank_cnt + 1'b1;
          ph        <= '0;
          pulse     <= '0;
        end
        S_DISPLAY: begin
          if (ph_last) begin
            ph <= '0;
            if (pulse_last) begin
              pulse       <= '0;
              row         <= row_wrap ? '0 : row + 1'b1;
              frame_start <= row_wrap;
            end else begin
              pulse <= pulse + 1'b1;
            end
          end else begin
            ph <= ph + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state decode; en is only consulted in IDLE and at the end of a row.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (en) state_nx = S_SHIFT;
      S_SHIFT:   if (ph_last && bit_last) state_nx = S_LATCH;
      S_LATCH:   if (ph_last) state_nx = S_BLANK;
      S_BLANK:   if (blank_last) state_nx = S_DISPLAY;
      S_DISPLAY: if (ph_last && pulse_last) state_nx = en ? S_SHIFT : S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Panel strobes and store request decoded from state and phase.
  always_comb begin
    fs.rd_en  = 1'b0;
    fs.rd_row = '0;
    fs.rd_bit = '0;
    dclk      = 1'b0;
    le        = 1'b0;
    gclk      = 1'b0;
    case (state)
      S_SHIFT: begin
        if (ph == '0) begin
          fs.rd_en  = 1'b1;
          fs.rd_row = row;
          fs.rd_bit = bit_idx;
        end
        dclk = (ph >= PH_W'(CLK_DIV));
      end
      S_LATCH:   le   = 1'b1;
      S_DISPLAY: gclk = (ph >= PH_W'(CLK_DIV)) && (pulse < bright_lim);
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE);
  assign sdo  = sdo_q;

`ifdef MATRIX_ROW_BD_SWAP_EN
  // Panels with B and D crossed: present row bit 3 on B and bit 1 on D.
  always_comb begin
    row_addr    = row_q;
    row_addr[1] = row_q[3];
    row_addr[3] = row_q[1];
  end
`else
  assign row_addr = row_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_matrix_scan_multi.sv
`default_nettype none
// Bench for matrix_scan_multi: random frame store contents and brightness,
// per-row observations gathered at the panel pins and compared with values
// derived from the row timing formula and the frame store contents.
module tb_matrix_scan_multi;
  localparam int CHANNELS     = 3;
  localparam int ROWS         = 16;
  localparam int ROW_BITS     = 4;
  localparam int SHIFT_LEN    = 48;
  localparam int CLK_DIV      = 2;
  localparam int BLANK_CYCLES = 8;
  localparam int GCLK_PULSES  = 64;
  localparam int PERIOD       = 2 * CLK_DIV;
  localparam int ROW_CYCLES   = SHIFT_LEN*PERIOD + PERIOD + BLANK_CYCLES + GCLK_PULSES*PERIOD;
  localparam int DISP_LEN     = BLANK_CYCLES + GCLK_PULSES*PERIOD;

  logic                clk = 1'b0;
  logic                rst;
  logic                en;
  logic [7:0]          brightness;
  logic [CHANNELS-1:0] sdo;
  logic                dclk, le, gclk;
  logic [ROW_BITS-1:0] row_addr;
  logic                frame_start, busy;

  matrix_scan_multi_if #(.CHANNELS(CHANNELS), .ROW_BITS(ROW_BITS), .SHIFT_LEN(SHIFT_LEN)) fs_if ();

  matrix_scan_multi #(
    .CHANNELS(CHANNELS), .ROWS(ROWS), .ROW_BITS(ROW_BITS), .SHIFT_LEN(SHIFT_LEN),
    .CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK_CYCLES), .GCLK_PULSES(GCLK_PULSES)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .brightness(brightness), .fs(fs_if),
    .sdo(sdo), .dclk(dclk), .le(le), .gclk(gclk), .row_addr(row_addr),
    .frame_start(frame_start), .busy(busy)
  );

  always #5 clk = ~clk;

  // Frame store: single-cycle latency, garbage when not requested.
  logic [CHANNELS-1:0] mem [ROWS][64];
  always @(posedge clk) begin
    if (fs_if.rd_en) fs_if.rd_data <= mem[fs_if.rd_row][fs_if.rd_bit];
    else             fs_if.rd_data <= CHANNELS'($urandom);
  end

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    int row; int dclks; int biterr; int lew; int br; int period;
    int gclks; int ra; int fs; int dlen; bit idle_end;
  } rec_t;

  rec_t cur;
  rec_t recq[$];
  int   cyc = 0, m_row = 0, m_latched = -1, last_le_rise = -1, le_fall_cyc = 0, blank_left = 0;
  bit   in_disp = 1'b0;
  int   unstable = 0, gbad = 0, ra_bad = 0, idle_dclk = 0, rd_err = 0, dclk_total = 0;
  logic dclk_p = 1'b0, le_p = 1'b0, gclk_p = 1'b0, busy_p = 1'b0;
  logic [CHANNELS-1:0] sdo_p = '0;
  logic [ROW_BITS-1:0] ra_p = '0;
  logic [7:0]          br_p = '0;

  function automatic logic [31:0] exp_ra(input int r);
    logic [ROW_BITS-1:0] v, t;
    v = r[ROW_BITS-1:0];
    t = v;
`ifdef MATRIX_ROW_BD_SWAP_EN
    v[1] = t[3];
    v[3] = t[1];
`endif
    return 32'(v);
  endfunction

  // Pin monitor: builds one record per displayed row.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      m_row = 0; in_disp = 1'b0; last_le_rise = -1; blank_left = 0;
      cur = '{default:0};
      recq.delete();
    end else begin
      if (frame_start) cur.fs++;
      if (fs_if.rd_en && fs_if.rd_row != m_row[ROW_BITS-1:0]) rd_err++;
      if (dclk && !busy) idle_dclk++;
      if (gclk && (dclk || le)) gbad++;
      if (gclk && blank_left > 0) gbad++;
      if (blank_left > 0) blank_left--;
      if (row_addr != ra_p && (gclk || dclk || le)) ra_bad++;
      if (in_disp && ((dclk && !dclk_p) || (!busy && busy_p))) begin
        cur.ra = int'(row_addr);
        cur.dlen = cyc - le_fall_cyc;
        cur.idle_end = !busy;
        recq.push_back(cur);
        cur = '{default:0};
        in_disp = 1'b0;
        if (!busy) last_le_rise = -1;
      end
      if (dclk && !dclk_p) begin
        dclk_total++;
        if (cur.dclks >= SHIFT_LEN || sdo !== mem[m_row][cur.dclks]) cur.biterr++;
        cur.dclks++;
      end
      if (dclk && dclk_p && sdo != sdo_p) unstable++;
      if (le && !le_p) begin
        cur.br = int'(br_p);
        cur.period = (last_le_rise < 0) ? -1 : cyc - last_le_rise;
        last_le_rise = cyc;
      end
      if (le) cur.lew++;
      if (!le && le_p) begin
        cur.row = m_row; m_latched = m_row; m_row = (m_row + 1) % ROWS;
        in_disp = 1'b1; le_fall_cyc = cyc; blank_left = BLANK_CYCLES - 1;
      end
      if (gclk && !gclk_p) cur.gclks++;
    end
    dclk_p = dclk; le_p = le; gclk_p = gclk; busy_p = busy;
    sdo_p = sdo; ra_p = row_addr; br_p = brightness;
  end

  task automatic chk(input logic [31:0] got, input logic [31:0] exp, input string tag);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk(32'(sdo), 0, {tag, " sdo"});
    chk(32'({dclk, le, gclk}), 0, {tag, " dclk/le/gclk"});
    chk(32'(row_addr), 0, {tag, " row_addr"});
    chk(32'({fs_if.rd_en, fs_if.rd_row, fs_if.rd_bit}), 0, {tag, " rd port"});
    chk(32'({frame_start, busy}), 0, {tag, " frame_start/busy"});
  endtask

  task automatic check_row();
    rec_t r;
    int   waited, exp_g;
    waited = 0;
    while (recq.size() == 0 && waited < 2*ROW_CYCLES) begin @(negedge clk); waited++; end
    n_checks++;
    assert (recq.size() != 0) else begin
      n_err++;
      $error("FAIL row_timeout: observed no completed row in %0d cycles, expected one", waited);
    end
    if (recq.size() != 0) begin
      r = recq.pop_front();
      exp_g = (r.br < GCLK_PULSES) ? r.br : GCLK_PULSES;
      chk(r.dclks,  SHIFT_LEN, $sformatf("dclk_edges row%0d", r.row));
      chk(r.biterr, 0,         $sformatf("sdo_bits row%0d", r.row));
      chk(r.lew,    PERIOD,    $sformatf("le_width row%0d", r.row));
      chk(r.gclks,  exp_g,     $sformatf("gclk_pulses row%0d br%0d", r.row, r.br));
      chk(r.ra,     exp_ra(r.row), $sformatf("row_addr row%0d", r.row));
      chk(r.fs,     (r.row == ROWS-1) ? 1 : 0, $sformatf("frame_start row%0d", r.row));
      chk(r.dlen,   DISP_LEN + (r.idle_end ? 0 : CLK_DIV), $sformatf("display_len row%0d", r.row));
      if (r.period >= 0) chk(r.period, ROW_CYCLES, $sformatf("row_period row%0d", r.row));
    end
  endtask

  function automatic logic [7:0] br_for(input int i);
    if (i < 2) return 8'd10;
    if (i < 4) return 8'd200;
    if (i < 6) return 8'd0;
    return 8'($urandom_range(255));
  endfunction

  initial begin
    int waited, snap;
    for (int r = 0; r < ROWS; r++)
      for (int b = 0; b < 64; b++) mem[r][b] = CHANNELS'($urandom);
    rst = 1'b1; en = 1'b1; brightness = 8'd10;
    @(posedge clk); @(negedge clk);
    check_zero("reset");
    repeat (2) @(posedge clk); #1 rst = 1'b0;

    // Two rows, then reset in the middle of the next row's shift.
    check_row();
    check_row();
    repeat (100) @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check_zero("mid_shift_reset");
    repeat (2) @(posedge clk); #1 rst = 1'b0; brightness = br_for(0);

    // Full frame plus wrap: directed then random brightness per row.
    for (int i = 0; i <= 20; i++) begin
      check_row();
      @(posedge clk); #1 brightness = br_for(i + 1);
    end

    // Drop en while row 5 is on display.
    waited = 0;
    while (!(in_disp && m_latched == 5) && waited < 2*ROW_CYCLES) begin @(negedge clk); waited++; end
    n_checks++;
    assert (in_disp && m_latched == 5) else begin
      n_err++;
      $error("FAIL row5_display: observed not reached after %0d cycles, expected reached", waited);
    end
    repeat (30) @(posedge clk); #1 en = 1'b0;
    check_row();
    snap = dclk_total;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk(32'(busy), 0, "idle_busy");
    chk(dclk_total, snap, "idle_dclk_edges");
    @(posedge clk); #1 en = 1'b1;
    check_row();
    check_row();

    chk(unstable, 0, "sdo_stable_in_dclk_high");
    chk(gclk_p === 1'b0 ? gbad : gbad, 0, "gclk_in_shift_latch_blank");
    chk(ra_bad, 0, "row_addr_change_window");
    chk(idle_dclk, 0, "dclk_while_idle");
    chk(rd_err, 0, "rd_row_sequence");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  // Absolute guard against a stalled run.
  initial begin
    #2000000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire

// File: doc/matrix_scan_multi.md
Name: matrix_scan_multi

Overview:
Parametrised successor to the single-panel LED matrix driver. One shared scan timing engine drives CHANNELS panels in lockstep: common DCLK/LE/GCLK/row-address, one SDO per channel. Pixel bits come from an external single-cycle-latency frame store through a read-request port. Adds row blanking (anti-ghosting), run/stop control, brightness gating and a frame-start strobe. Instantiated once at chip top in place of per-panel drivers.

Parameters:
CHANNELS, 3, number of panels (SDO outputs / rd_data bits)
ROWS, 16, scan rows per frame; ROWS <= 2**ROW_BITS
ROW_BITS, 4, width of row address
SHIFT_LEN, 48, bits shifted per row per channel
CLK_DIV, 2, DCLK/GCLK half-period in clk cycles; minimum 2
BLANK_CYCLES, 8, clk cycles with GCLK low after row change
GCLK_PULSES, 64, GCLK periods per row display slot

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
en  in  1  run enable; sampled in IDLE and at end of DISPLAY
brightness  in  8  GCLK pulses actually emitted per row; sampled on LATCH entry
rd_en  out  1  frame-store read strobe
rd_row  out  ROW_BITS  row of requested bit
rd_bit  out  $clog2(SHIFT_LEN)  bit index within row
rd_data  in  CHANNELS  one bit per channel, valid the cycle after rd_en
sdo  out  CHANNELS  serial data to panel drivers
dclk  out  1  shift clock, shared
le  out  1  latch enable, shared
gclk  out  1  grayscale/display clock, shared
row_addr  out  ROW_BITS  row select (A=bit0 … D=bit3)
frame_start  out  1  one-cycle pulse when row wraps to 0
busy  out  1  high whenever state != IDLE

Behaviour:
- Clock is clk; reset is synchronous, active-high. On rst: state IDLE, row=0, all outputs 0 (sdo, dclk, le, gclk, row_addr, rd_en, rd_row, rd_bit, frame_start, busy). Reset mid-operation aborts immediately; no partial latch.
- States: IDLE -> SHIFT -> LATCH -> BLANK -> DISPLAY -> (SHIFT | IDLE).
- IDLE: outputs held 0 except row_addr (holds last value). en=1 -> SHIFT with bit=0, next cycle.
- SHIFT: phase counter ph 0..2*CLK_DIV-1 per bit. ph=0: rd_en=1, rd_row=row, rd_bit=bit. ph=1: sdo<=rd_data. ph=CLK_DIV..2*CLK_DIV-1: dclk=1; else dclk=0. sdo stable for the whole dclk-high window. After bit SHIFT_LEN-1 completes -> LATCH. Exactly SHIFT_LEN rising dclk edges per row.
- LATCH: le=1 for 2*CLK_DIV cycles, dclk=0, gclk=0. Captures brightness into bright_q. -> BLANK.
- BLANK: gclk=0; row_addr<=row on first BLANK cycle; stays BLANK_CYCLES cycles -> DISPLAY. row_addr never changes outside the first BLANK cycle (and reset).
- DISPLAY: GCLK_PULSES periods of 2*CLK_DIV cycles; gclk high in second half of period p only if p < min(bright_q, GCLK_PULSES). brightness=0 -> gclk stays 0, timing unchanged. Slot length fixed regardless of brightness.
- End of DISPLAY: row <= (row==ROWS-1) ? 0 : row+1; on wrap frame_start=1 for that one cycle. Then en=1 -> SHIFT; en=0 -> IDLE. en deassert mid-row never truncates the row.
- brightness changes outside LATCH entry take effect next row.
- Cycles per row = SHIFT_LEN*2*CLK_DIV + 2*CLK_DIV + BLANK_CYCLES + GCLK_PULSES*2*CLK_DIV (+1 transition cycle per state change where the implementation requires; fixed, documented constant).

Optional Feature:
MATRIX_ROW_BD_SWAP_EN: when defined, row_addr bit1 and bit3 are swapped on output (panel wiring with B/D crossed; requires ROW_BITS>=4). Internal row, rd_row and frame_start unaffected. Undefined: row_addr = row directly.

Test Plan:
- rst held 3 cycles mid-SHIFT with en=1 -> all outputs 0 the cycle after rst sampled; row restarts at 0 after release.
- Defaults, en=1, rd_data=3'b101 constant -> exactly 48 dclk rising edges per row, sdo=3'b101 on every edge, then one le pulse 4 cycles wide, gclk=0 throughout.
- brightness=10, GCLK_PULSES=64 -> exactly 10 gclk pulses per row; brightness=200 -> 64 pulses; brightness=0 -> 0 pulses, row period identical in all three cases.
- Run 16 rows -> row_addr steps 0..15 only in BLANK with gclk=0; frame_start pulses once per 16 rows, on the 15->0 wrap.
- Drop en during DISPLAY of row 5 -> row 5 finishes, row advances to 6, IDLE, busy=0, no further dclk; re-raise en -> SHIFT of row 6.
- MATRIX_ROW_BD_SWAP_EN defined, row=2 (0010) -> row_addr=4'b1000; row=8 -> 4'b0010; rd_row unchanged.
